// File: rtl/cache_types.sv
// Shared cache type definitions: tag-array line state plus the instruction
// refill controller's FSM encoding and sizing helper.
package cache_types;

  // Per-line state kept by the tag array.
  typedef enum logic [1:0] {
    LINE_INVALID,
    LINE_VALID,
    LINE_PENDING
  } state_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL,
    WRITE
  } refill_state_t;

  // Beat counter width; a one-beat line still gets a 1-bit counter.
  function automatic int beat_cnt_w(input int line_w, input int beat_w);
    return (line_w / beat_w > 1) ? $clog2(line_w / beat_w) : 1;
  endfunction

endpackage

// File: rtl/line_assembler.sv
// Collects memory beats into a full cache line, one beat slot per write.
module line_assembler #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int SLOT_W = 2
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [SLOT_W-1:0] i_slot,
  input  logic [BEAT_W-1:0] i_beat,
  output logic [LINE_W-1:0] o_line
);

  logic [LINE_W-1:0] r_line;

  // NOTE: line storage is pure datapath and is fully overwritten before every
  // write-back, so it carries no reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_line[int'(i_slot) * BEAT_W +: BEAT_W] <= i_beat;
    end
  end

  assign o_line = r_line;

endmodule

// File: rtl/inst_refill_ctrl.sv
// Instruction cache refill controller: requests a line from memory, assembles
// its beats and writes it into the victim way, with flush-abandon support.
module inst_refill_ctrl
  import cache_types::*;
#(
  parameter int WAYS            = 4,
  parameter int TAG_SIZE        = 24,
  parameter int CACHE_LINE_SIZE = 256,
  parameter int BEAT_WIDTH      = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       miss_valid,
  input  logic [31:0]                miss_addr,
  input  logic [$clog2(WAYS)-1:0]    victim_way,
  input  logic                       flush,
  input  logic                       mem_ready,
  input  logic                       mem_resp,
  input  logic [BEAT_WIDTH-1:0]      mem_rdata,
  output logic                       mem_read,
  output logic [31:0]                mem_addr,
  output logic                       busy,
  output logic                       cache_we_n,
  output logic [$clog2(WAYS)-1:0]    cache_way,
  output logic [TAG_SIZE-1:0]        cache_tag,
  output logic [CACHE_LINE_SIZE-1:0] cache_line,
  output logic                       refill_done
);

  localparam int BEATS = CACHE_LINE_SIZE / BEAT_WIDTH;
  localparam int CNT_W = beat_cnt_w(CACHE_LINE_SIZE, BEAT_WIDTH);
  localparam int WAY_W = $clog2(WAYS);

  refill_state_t    r_state;
  refill_state_t    w_next_state;
  logic [31:0]      r_addr;
  logic [WAY_W-1:0] r_way;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_drop;
  logic             w_beat_we;
  logic             w_last_beat;

  assign w_beat_we   = (r_state == FILL) && mem_resp;
  assign w_last_beat = w_beat_we && (r_beat_cnt == CNT_W'(BEATS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_beat_cnt <= '0;
      r_drop     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_beat_we) begin
        r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
      end
      // A flush once the request is accepted cannot cancel the burst, only its write-back.
      if (flush && (r_state == FILL || (r_state == REQ && mem_ready))) begin
        r_drop <= 1'b1;
      end else if (r_state == IDLE) begin
        r_drop <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == IDLE && miss_valid) begin
      r_addr <= miss_addr;
      r_way  <= victim_way;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    w_next_state = r_state;
    mem_read     = 1'b0;
    busy         = 1'b1;
    cache_we_n   = 1'b1;
    refill_done  = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (miss_valid) w_next_state = REQ;
      end
      REQ: begin
        mem_read = 1'b1;
        if (mem_ready)  w_next_state = FILL;
        else if (flush) w_next_state = IDLE;
      end
      FILL: begin
        if (w_last_beat) w_next_state = (r_drop || flush) ? IDLE : WRITE;
      end
      WRITE: begin
        cache_we_n   = 1'b0;
        refill_done  = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  line_assembler #(
    .LINE_W (CACHE_LINE_SIZE),
    .BEAT_W (BEAT_WIDTH),
    .SLOT_W (CNT_W)
  ) u_line_assembler (
    .clk    (clk),
    .i_we   (w_beat_we),
    .i_slot (r_beat_cnt),
    .i_beat (mem_rdata),
    .o_line (cache_line)
  );

  assign mem_addr  = r_addr;
  assign cache_way = r_way;
  assign cache_tag = r_addr[31 -: TAG_SIZE];

endmodule

// File: tb/tb_inst_refill_ctrl.sv
// Self-checking bench for inst_refill_ctrl: default 64-bit-beat instance and a
// 32-bit-beat instance, checked against a line/tag model built from the beats.
module tb_inst_refill_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  // Default-parameter instance
  logic         miss_valid = 1'b0;
  logic [31:0]  miss_addr  = '0;
  logic [1:0]   victim_way = '0;
  logic         flush      = 1'b0;
  logic         mem_ready  = 1'b0;
  logic         mem_resp   = 1'b0;
  logic [63:0]  mem_rdata  = '0;
  logic         mem_read, busy, cache_we_n, refill_done;
  logic [31:0]  mem_addr;
  logic [1:0]   cache_way;
  logic [23:0]  cache_tag;
  logic [255:0] cache_line;

  inst_refill_ctrl dut (
    .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_addr(miss_addr),
    .victim_way(victim_way), .flush(flush), .mem_ready(mem_ready),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .mem_read(mem_read),
    .mem_addr(mem_addr), .busy(busy), .cache_we_n(cache_we_n),
    .cache_way(cache_way), .cache_tag(cache_tag), .cache_line(cache_line),
    .refill_done(refill_done)
  );

  // 32-bit-beat instance (8 beats per line)
  logic         w_miss_valid = 1'b0;
  logic [31:0]  w_miss_addr  = '0;
  logic [1:0]   w_victim_way = '0;
  logic         w_flush      = 1'b0;
  logic         w_mem_ready  = 1'b0;
  logic         w_mem_resp   = 1'b0;
  logic [31:0]  w_mem_rdata  = '0;
  logic         w_mem_read, w_busy, w_cache_we_n, w_refill_done;
  logic [31:0]  w_mem_addr;
  logic [1:0]   w_cache_way;
  logic [23:0]  w_cache_tag;
  logic [255:0] w_cache_line;

  inst_refill_ctrl #(.BEAT_WIDTH(32), .CACHE_LINE_SIZE(256)) dut32 (
    .clk(clk), .rst(rst), .miss_valid(w_miss_valid), .miss_addr(w_miss_addr),
    .victim_way(w_victim_way), .flush(w_flush), .mem_ready(w_mem_ready),
    .mem_resp(w_mem_resp), .mem_rdata(w_mem_rdata), .mem_read(w_mem_read),
    .mem_addr(w_mem_addr), .busy(w_busy), .cache_we_n(w_cache_we_n),
    .cache_way(w_cache_way), .cache_tag(w_cache_tag), .cache_line(w_cache_line),
    .refill_done(w_refill_done)
  );

  // Write-enable and done pulse counters, sampled mid-cycle
  int we_cnt = 0, done_cnt = 0, w_we_cnt = 0;
  always @(negedge clk) begin
    if (!cache_we_n)   we_cnt++;
    if (refill_done)   done_cnt++;
    if (!w_cache_we_n) w_we_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0][63:0] rand_beats();
    logic [3:0][63:0] r;
    for (int i = 0; i < 4; i++) r[i] = {$urandom, $urandom};
    return r;
  endfunction

  // Full refill on the default instance; flush_after >= 0 flushes in the cycle
  // after that beat index, which must abandon the write-back.
  task automatic run_refill(input logic [31:0] addr, input logic [1:0] way,
                            input int rdy_dly, input int gap, input int flush_after,
                            input logic [3:0][63:0] beats, input string name);
    logic [255:0] exp_line;
    bit           drop;
    int           t0;
    drop     = (flush_after >= 0);
    exp_line = {beats[3], beats[2], beats[1], beats[0]};
    we_cnt   = 0;
    done_cnt = 0;
    t0       = cyc;
    miss_valid = 1'b1; miss_addr = addr; victim_way = way;
    tick();
    miss_valid = 1'b0; miss_addr = $urandom; victim_way = 2'($urandom);
    for (int d = 0; d <= rdy_dly; d++) begin
      checks++;
      if (mem_read !== 1'b1 || mem_addr !== addr || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s req[%0d]: mem_read=%b mem_addr=%h busy=%b, expected 1 %h 1",
                 name, d, mem_read, mem_addr, busy, addr);
      end
      mem_ready = (d == rdy_dly);
      mem_resp  = 1'($urandom);
      mem_rdata = {$urandom, $urandom};
      tick();
    end
    mem_ready = 1'b0;
    mem_resp  = 1'b0;
    checks++;
    if (mem_read !== 1'b0) begin
      errors++;
      $display("FAIL %s mem_read after accept: got %b expected 0", name, mem_read);
    end
    for (int b = 0; b < 4; b++) begin
      repeat (gap) begin
        mem_rdata  = {$urandom, $urandom};
        miss_valid = 1'($urandom);
        tick();
      end
      miss_valid = 1'b0;
      mem_resp   = 1'b1;
      mem_rdata  = beats[b];
      tick();
      mem_resp = 1'b0;
      if (b == flush_after) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end
    end
    if (!drop) begin
      checks++;
      if (cache_we_n !== 1'b0 || refill_done !== 1'b1 || cache_way !== way ||
          cache_tag !== addr[31:8] || cache_line !== exp_line) begin
        errors++;
        $display("FAIL %s write: we_n=%b done=%b way=%0d tag=%h line=%h, expected 0 1 %0d %h %h",
                 name, cache_we_n, refill_done, cache_way, cache_tag, cache_line,
                 way, addr[31:8], exp_line);
      end
      if (rdy_dly == 0 && gap == 0) begin
        checks++;
        if (cyc - t0 !== 6) begin
          errors++;
          $display("FAIL %s latency: write %0d cycles after miss, expected 6", name, cyc - t0);
        end
      end
      flush = 1'($urandom);
      tick();
      flush = 1'b0;
    end
    checks++;
    if (busy !== 1'b0 || cache_we_n !== 1'b1 || refill_done !== 1'b0) begin
      errors++;
      $display("FAIL %s end: busy=%b we_n=%b done=%b, expected 0 1 0",
               name, busy, cache_we_n, refill_done);
    end
    tick();
    checks++;
    if (we_cnt !== (drop ? 0 : 1) || done_cnt !== (drop ? 0 : 1)) begin
      errors++;
      $display("FAIL %s pulse count: we=%0d done=%0d, expected %0d",
               name, we_cnt, done_cnt, drop ? 0 : 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || mem_read !== 1'b0 || cache_we_n !== 1'b1 || refill_done !== 1'b0 ||
        w_busy !== 1'b0 || w_cache_we_n !== 1'b1) begin
      errors++;
      $display("FAIL reset: busy=%b mem_read=%b we_n=%b done=%b w_busy=%b w_we_n=%b, expected 0 0 1 0 0 1",
               busy, mem_read, cache_we_n, refill_done, w_busy, w_cache_we_n);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    run_refill(32'h0000_1000, 2'd2, 0, 0, -1,
               {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, "basic");
  endtask

  task automatic test_slow_mem();
    run_refill(32'hABCD_E0E0, 2'd1, 5, 3, -1, rand_beats(), "slow_mem");
  endtask

  task automatic test_flush_fill();
    run_refill(32'h0012_3400, 2'd3, 0, 0, 1, rand_beats(), "flush_fill");
  endtask

  task automatic test_flush_req();
    // Flush while waiting for acceptance: back to idle, nothing written.
    we_cnt = 0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: busy=%b expected 0", busy);
    end
    miss_valid = 1'b1; miss_addr = 32'h0000_2000; victim_way = 2'd0;
    tick();
    miss_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL flush_req: busy=%b mem_read=%b expected 0 0", busy, mem_read);
    end
    // Flush coinciding with acceptance: burst consumed, write dropped.
    miss_valid = 1'b1; miss_addr = 32'h0000_3000; victim_way = 2'd1;
    tick();
    miss_valid = 1'b0;
    flush = 1'b1; mem_ready = 1'b1;
    tick();
    flush = 1'b0; mem_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mem_resp = 1'b1; mem_rdata = {$urandom, $urandom};
      tick();
    end
    mem_resp = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_accept: busy=%b after last beat, expected 0", busy);
    end
    repeat (2) tick();
    checks++;
    if (we_cnt !== 0) begin
      errors++;
      $display("FAIL flush_req we count: got %0d expected 0", we_cnt);
    end
  endtask

  task automatic test_reset_mid();
    we_cnt = 0;
    miss_valid = 1'b1; miss_addr = 32'h0000_4000; victim_way = 2'd3;
    tick();
    miss_valid = 1'b0; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; mem_resp = 1'b1; mem_rdata = {$urandom, $urandom};
    tick();
    mem_resp = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || mem_read !== 1'b0 || cache_we_n !== 1'b1 || refill_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b mem_read=%b we_n=%b done=%b, expected 0 0 1 0",
               busy, mem_read, cache_we_n, refill_done);
    end
    for (int b = 0; b < 3; b++) begin
      mem_resp = 1'b1; mem_rdata = {$urandom, $urandom};
      tick();
    end
    mem_resp = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || we_cnt !== 0) begin
      errors++;
      $display("FAIL reset_mid stray beats: busy=%b we=%0d, expected 0 0", busy, we_cnt);
    end
    run_refill(32'h0000_5000, 2'd2, 1, 0, -1, rand_beats(), "after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      run_refill($urandom & ~32'h1F, 2'($urandom), $urandom_range(0, 4),
                 $urandom_range(0, 2), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : -1,
                 rand_beats(), "random");
    end
  endtask

  task automatic test_wide();
    logic [7:0][31:0] beats;
    logic [255:0]     exp_line;
    logic [31:0]      addr;
    logic [1:0]       way;
    int               rdy;
    for (int i = 0; i < 8; i++) beats[i] = $urandom;
    exp_line = '0;
    for (int i = 0; i < 8; i++) exp_line = exp_line | (256'(beats[i]) << (32 * i));
    addr = $urandom & ~32'h1F;
    way  = 2'($urandom);
    rdy  = $urandom_range(0, 3);
    w_we_cnt = 0;
    w_miss_valid = 1'b1; w_miss_addr = addr; w_victim_way = way;
    tick();
    w_miss_valid = 1'b0;
    for (int d = 0; d <= rdy; d++) begin
      w_mem_ready = (d == rdy);
      tick();
    end
    w_mem_ready = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (b == 2) begin
        w_miss_valid = 1'b1; w_miss_addr = ~addr; w_victim_way = ~way;
        tick();
        w_miss_valid = 1'b0;
      end
      w_mem_resp = 1'b1; w_mem_rdata = beats[b];
      tick();
      w_mem_resp = 1'b0;
    end
    checks++;
    if (w_cache_we_n !== 1'b0 || w_refill_done !== 1'b1 || w_cache_way !== way ||
        w_cache_tag !== addr[31:8] || w_cache_line !== exp_line) begin
      errors++;
      $display("FAIL wide write: we_n=%b done=%b way=%0d tag=%h line=%h, expected 0 1 %0d %h %h",
               w_cache_we_n, w_refill_done, w_cache_way, w_cache_tag, w_cache_line,
               way, addr[31:8], exp_line);
    end
    repeat (4) tick();
    checks++;
    if (w_busy !== 1'b0 || w_we_cnt !== 1) begin
      errors++;
      $display("FAIL wide after: busy=%b we=%0d, expected 0 1", w_busy, w_we_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_slow_mem();
    test_flush_fill();
    test_flush_req();
    test_reset_mid();
    test_random();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
